// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch stage with one outstanding imem fetch, skid buffer and IF/ID register
// Ports: clk, rst (async, active-high);
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata: fetch handshake, one fetch outstanding at most;
//   stall: hold IF/ID; branch_taken/branch_target: flush IF/ID and redirect pc;
//   if_id_valid/if_id_pc/if_id_instr/if_id_opcode: IF/ID pipeline register towards decode/control.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode
);
  localparam logic [1:0] REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [31:0] pc, reqPc, skidPc, skidInstr, newPc, newInstr, target;
  logic drop, grant, respOk, newAvail, toSkid;
  assign imem_req = (state == REQ) & ~rst;
  assign imem_addr = pc;
  assign if_id_opcode = if_id_instr[6:0];
  always_comb begin
    grant = imem_req & imem_gnt;
    respOk = (state == WAIT) & imem_rvalid & ~drop;
    toSkid = respOk & ~branch_taken & stall;
    newAvail = respOk | (state == HOLD);
    newPc = (state == HOLD) ? skidPc : reqPc;
    newInstr = (state == HOLD) ? skidInstr : imem_rdata;
    target = branch_target & ~32'd3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
      pc <= RESET_PC;
      reqPc <= '0;
      drop <= 1'b0;
      skidPc <= '0;
      skidInstr <= 32'h0000_0013;
      if_id_valid <= 1'b0;
      if_id_pc <= '0;
      if_id_instr <= 32'h0000_0013;
    end else begin
      pc <= branch_taken ? target : grant ? pc + 32'd4 : pc;
      if (grant) reqPc <= pc;
      case (state)
        REQ: if (grant) begin
          state <= WAIT;
          drop <= branch_taken;
        end
        WAIT: if (imem_rvalid) begin
          state <= toSkid ? HOLD : REQ;
          drop <= 1'b0;
        end else if (branch_taken) drop <= 1'b1;
        default: if (branch_taken | ~stall) state <= REQ;
      endcase
      if (toSkid) begin
        skidPc <= reqPc;
        skidInstr <= imem_rdata;
      end
      // flush beats stall; a bubble keeps the old pc/instr and only clears valid
      if (branch_taken) if_id_valid <= 1'b0;
      else if (!stall) begin
        if_id_valid <= newAvail;
        if (newAvail) begin
          if_id_pc <= newPc;
          if_id_instr <= newInstr;
        end
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage with a latency-programmable instruction memory model
module tb_if_stage;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic clk = 1'b0;
  logic rst, gnt, stall, br, rvalid, busy, rvalid2;
  logic [31:0] tgt, rdata, pa, addr, addr2, ifPc, ifPc2, ifInstr, ifInstr2;
  logic req, req2, ifValid, ifValid2;
  logic [6:0] ifOp, ifOp2;
  int lat, cnt, compared, mismatched, popCount;
  logic lastValid;
  logic [31:0] lastPc;
  ent_t q[$];
  always #5 clk = ~clk;
  if_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .stall(stall), .branch_taken(br),
    .branch_target(tgt), .if_id_valid(ifValid), .if_id_pc(ifPc), .if_id_instr(ifInstr),
    .if_id_opcode(ifOp)
  );
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(32'h0000_0013), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .if_id_valid(ifValid2), .if_id_pc(ifPc2), .if_id_instr(ifInstr2),
    .if_id_opcode(ifOp2)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h104) ? 32'h0020_8033 : {a[23:0], 1'b0, a[8:2]};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      busy <= 1'b0;
      cnt <= 0;
      pa <= '0;
      rdata <= '0;
    end else begin
      rvalid <= 1'b0;
      if (req && gnt) begin
        pa <= addr;
        if (lat == 1) begin
          rvalid <= 1'b1;
          rdata <= mem(addr);
          busy <= 1'b0;
        end else begin
          busy <= 1'b1;
          cnt <= lat - 1;
        end
      end else if (busy) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          rvalid <= 1'b1;
          rdata <= mem(pa);
          busy <= 1'b0;
        end
      end
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) rvalid2 <= 1'b0;
    else rvalid2 <= req2;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one clock: record grants/redirects at the edge, then score IF/ID at the following negedge
  task automatic step();
    logic g, b;
    logic [31:0] a;
    ent_t e;
    #1;
    g = req & gnt;
    a = addr;
    b = br;
    @(posedge clk);
    if (g) q.push_back('{pc: a, instr: mem(a)});
    if (b) q.delete();
    @(negedge clk);
    if (ifValid && (!lastValid || ifPc != lastPc)) begin
      chk("sb_pending", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        popCount++;
        chk("sb_pc", ifPc, e.pc);
        chk("sb_instr", ifInstr, e.instr);
        chk("sb_opcode", 32'(ifOp), 32'(e.instr[6:0]));
      end
    end
    lastValid = ifValid;
    lastPc = ifPc;
  endtask
  initial begin
    compared = 0;
    mismatched = 0;
    popCount = 0;
    lastValid = 1'b0;
    lastPc = '0;
    rst = 1'b1;
    gnt = 1'b1;
    stall = 1'b0;
    br = 1'b0;
    tgt = '0;
    lat = 1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ifValid), 32'd0);
    chk("rst_pc", ifPc, 32'h0);
    chk("rst_instr", ifInstr, 32'h0000_0013);
    chk("rst_opcode", 32'(ifOp), 32'h13);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_req_wrap", 32'(req2), 32'd0);
    rst = 1'b0;
    #1;
    chk("c0_req", 32'(req), 32'd1);
    chk("c0_addr", addr, 32'h100);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    step();
    chk("c1_req", 32'(req), 32'd0);
    chk("c1_valid", 32'(ifValid), 32'd0);
    step();
    chk("c2_req", 32'(req), 32'd1);
    chk("c2_addr", addr, 32'h104);
    chk("c2_valid", 32'(ifValid), 32'd1);
    chk("wrap_addr1", addr2, 32'h0);
    stall = 1'b1;
    step();
    chk("stall_c3_req", 32'(req), 32'd0);
    chk("stall_c3_pc", ifPc, 32'h100);
    chk("stall_c3_valid", 32'(ifValid), 32'd1);
    step();
    chk("stall_c4_req", 32'(req), 32'd0);
    chk("stall_c4_pc", ifPc, 32'h100);
    step();
    chk("stall_c5_req", 32'(req), 32'd0);
    chk("stall_c5_pc", ifPc, 32'h100);
    stall = 1'b0;
    lat = 2;
    step();
    chk("unstall_pc", ifPc, 32'h104);
    chk("unstall_instr", ifInstr, 32'h0020_8033);
    chk("c6_addr", addr, 32'h108);
    step();
    br = 1'b1;
    tgt = 32'h203;
    step();
    br = 1'b0;
    lat = 1;
    chk("redir_valid", 32'(ifValid), 32'd0);
    chk("redir_wait_req", 32'(req), 32'd0);
    step();
    chk("redir_req", 32'(req), 32'd1);
    chk("redir_addr", addr, 32'h200);
    step();
    chk("redir_drop_valid", 32'(ifValid), 32'd0);
    step();
    chk("c11_addr", addr, 32'h204);
    br = 1'b1;
    stall = 1'b1;
    tgt = 32'h300;
    step();
    br = 1'b0;
    stall = 1'b0;
    chk("flush_vs_stall", 32'(ifValid), 32'd0);
    step();
    chk("grant_redir_addr", addr, 32'h300);
    chk("grant_redir_req", 32'(req), 32'd1);
    chk("stale_hidden", 32'(ifValid), 32'd0);
    step();
    step();
    stall = 1'b1;
    step();
    chk("pre_rst_valid", 32'(ifValid), 32'd1);
    rst = 1'b1;
    stall = 1'b0;
    q.delete();
    lastValid = 1'b0;
    #1;
    chk("midrst_valid", 32'(ifValid), 32'd0);
    chk("midrst_instr", ifInstr, 32'h0000_0013);
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_addr", addr, 32'h100);
    step();
    rst = 1'b0;
    #1;
    chk("restart_req", 32'(req), 32'd1);
    chk("restart_addr", addr, 32'h100);
    step();
    step();
    chk("pop_count", 32'(popCount), 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
